// File: rtl/ftsd_scan.sv
`default_nettype none
// ============================================================================
//  Module   : ftsd_scan
//  Purpose  : Four-digit 14-segment (+dot) display scanner. Characters are
//             accepted via a valid/ready handshake, scrolled in from the right
//             into a four-entry buffer, and time-multiplexed onto one shared
//             active-low segment bus.
//             Optional macro FTSD_BLANK_EN blanks the first quarter of each
//             digit slot to suppress ghosting.
//  Revision : 1.0 - initial release
// ============================================================================
module ftsd_scan #(
  parameter int REFRESH_BITS = 16,
  parameter int HOLD_CYCLES  = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [14:0] in_pattern,
  output logic        in_ready,
  input  logic        clear,
  output logic [3:0]  ftsd_ctl,
  output logic [14:0] display
);

  localparam logic [14:0] BLANK  = 15'h7FFF;
  localparam int          HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                  state;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [REFRESH_BITS-1:0] scan_cnt;
  logic [14:0]             digit [4];
  logic [1:0]              sel;
  logic                    transfer;

  // Ready is dropped during clear so a simultaneous in_valid can never transfer.
  assign in_ready = (state == IDLE) && !clear;
  assign transfer = in_valid && in_ready;
  assign sel      = scan_cnt[REFRESH_BITS-1:REFRESH_BITS-2];

  // Handshake FSM, hold timer and scrolling digit buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      for (int i = 0; i < 4; i++) digit[i] <= BLANK;
    end else if (clear) begin
      state    <= IDLE;
      hold_cnt <= '0;
      for (int i = 0; i < 4; i++) digit[i] <= BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            state    <= HOLD;
            hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
            digit[3] <= digit[2];
            digit[2] <= digit[1];
            digit[1] <= digit[0];
            digit[0] <= in_pattern;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  // Free-running scan counter; deliberately ignores clear so the refresh never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + REFRESH_BITS'(1);
    end
  end

  // Registered digit enable and segment outputs, one cycle behind counter and buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftsd_ctl <= 4'b1111;
      display  <= BLANK;
    end else begin
`ifdef FTSD_BLANK_EN
      if (scan_cnt[REFRESH_BITS-3:REFRESH_BITS-4] == 2'b00) begin
        ftsd_ctl <= 4'b1111;
        display  <= BLANK;
      end else begin
        ftsd_ctl <= ~(4'b0001 << sel);
        display  <= digit[sel];
      end
`else
      ftsd_ctl <= ~(4'b0001 << sel);
      display  <= digit[sel];
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ftsd_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ftsd_scan
//  Purpose  : Directed self-checking bench for ftsd_scan (REFRESH_BITS=4,
//             HOLD_CYCLES=3). Honours FTSD_BLANK_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ftsd_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [14:0] in_pattern = 15'h0;
  logic        clear = 1'b0;
  logic        in_ready;
  logic [3:0]  ftsd_ctl;
  logic [14:0] display;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  m_cnt;
  logic [14:0] exp_d [4];

  ftsd_scan #(
    .REFRESH_BITS(4),
    .HOLD_CYCLES (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pattern(in_pattern),
    .in_ready  (in_ready),
    .clear     (clear),
    .ftsd_ctl  (ftsd_ctl),
    .display   (display)
  );

  always #5 clk = ~clk;

  // Reference scan counter: free-running from reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= 4'd0;
    else     m_cnt <= m_cnt + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] calc_ctl(input logic [3:0] pc);
    logic blank;
`ifdef FTSD_BLANK_EN
    blank = (pc[1:0] == 2'b00);
`else
    blank = 1'b0;
`endif
    case (pc[3:2])
      2'd0:    calc_ctl = 4'b1110;
      2'd1:    calc_ctl = 4'b1101;
      2'd2:    calc_ctl = 4'b1011;
      default: calc_ctl = 4'b0111;
    endcase
    if (blank) calc_ctl = 4'b1111;
  endfunction

  function automatic logic [14:0] calc_disp(input logic [3:0] pc);
    logic blank;
`ifdef FTSD_BLANK_EN
    blank = (pc[1:0] == 2'b00);
`else
    blank = 1'b0;
`endif
    calc_disp = blank ? 15'h7FFF : exp_d[pc[3:2]];
  endfunction

  task automatic blank_buf();
    for (int i = 0; i < 4; i++) exp_d[i] = 15'h7FFF;
  endtask

  task automatic push(input logic [14:0] p);
    exp_d[3] = exp_d[2];
    exp_d[2] = exp_d[1];
    exp_d[1] = exp_d[0];
    exp_d[0] = p;
  endtask

  // Outputs after an edge reflect the counter value just before that edge.
  task automatic check_scan(input string tag, input int n);
    logic [3:0] pc;
    for (int i = 0; i < n; i++) begin
      step();
      pc = m_cnt - 4'd1;
      chk({tag, "_ctl"}, ftsd_ctl, calc_ctl(pc));
      chk({tag, "_disp"}, display, calc_disp(pc));
    end
  endtask

  task automatic send(input logic [14:0] p);
    logic done;
    done       = 1'b0;
    in_valid   = 1'b1;
    in_pattern = p;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("send_ready_seen", {31'd0, done}, 32'd1);
    if (done) begin
      push(p);
      chk("ready_low_after_xfer", {31'd0, in_ready}, 32'd0);
    end
  endtask

  initial begin
    blank_buf();

    // Reset state
    repeat (3) step();
    chk("rst_ctl", ftsd_ctl, 4'b1111);
    chk("rst_disp", display, 15'h7FFF);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    #3 rst = 1'b0;
    step();
    chk("first_ctl", ftsd_ctl, calc_ctl(4'd0));
    chk("first_disp", display, 15'h7FFF);

    // Load four characters, then watch a full scan period
    send(15'h0001);
    send(15'h0002);
    send(15'h0004);
    send(15'h0008);
    chk("load_d0", exp_d[0], 15'h0008);
    check_scan("load", 16);

    // Fifth character scrolls the oldest out
    send(15'h0010);
    check_scan("scroll", 16);

    // Streaming producer: transfers at t, t+4, t+8; pattern changes while busy ignored
    chk("hs_pre_ready", {31'd0, in_ready}, 32'd1);
    in_valid   = 1'b1;
    in_pattern = 15'h0020;
    step();
    chk("hs_t0", {31'd0, in_ready}, 32'd0);
    in_pattern = 15'h5555;
    step();
    chk("hs_t1", {31'd0, in_ready}, 32'd0);
    step();
    chk("hs_t2", {31'd0, in_ready}, 32'd0);
    step();
    chk("hs_t3", {31'd0, in_ready}, 32'd1);
    in_pattern = 15'h0040;
    step();
    chk("hs_t4", {31'd0, in_ready}, 32'd0);
    in_pattern = 15'h5555;
    repeat (3) step();
    chk("hs_t7", {31'd0, in_ready}, 32'd1);
    in_pattern = 15'h0080;
    step();
    chk("hs_t8", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    push(15'h0020);
    push(15'h0040);
    push(15'h0080);
    check_scan("stream", 16);

    // Asynchronous reset mid-HOLD
    send(15'h0100);
    #2 rst = 1'b1;
    #1;
    chk("async_ctl", ftsd_ctl, 4'b1111);
    chk("async_disp", display, 15'h7FFF);
    #1 rst = 1'b0;
    blank_buf();
    step();
    chk("rel_ctl", ftsd_ctl, calc_ctl(4'd0));
    chk("rel_disp", display, 15'h7FFF);
    chk("rel_ready", {31'd0, in_ready}, 32'd1);
    check_scan("post_rst", 16);

    // Clear during HOLD with in_valid high
    send(15'h0100);
    in_valid   = 1'b1;
    in_pattern = 15'h0200;
    clear      = 1'b1;
    #1;
    chk("clr_hold_ready", {31'd0, in_ready}, 32'd0);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clr_hold_after", {31'd0, in_ready}, 32'd1);
    blank_buf();
    check_scan("clear", 16);

    // Clear in IDLE overrides a simultaneous in_valid
    in_valid   = 1'b1;
    in_pattern = 15'h0400;
    clear      = 1'b1;
    #1;
    chk("clr_idle_ready", {31'd0, in_ready}, 32'd0);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clr_idle_after", {31'd0, in_ready}, 32'd1);
    check_scan("clr_idle", 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
